// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: DEPTH-entry elastic pipeline buffer with registered allow_in, flush and stall counter
module pipe_stage_buf #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [DATA_W-1:0]            in_bus,
   output logic                         in_allow_in,
   output logic                         out_valid,
   output logic [DATA_W-1:0]            out_bus,
   input  logic                         out_allow_in,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [CNT_W-1:0]             stall_cnt
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int OW = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr, wr_ptr;
   logic              push, pop;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign in_allow_in = occupancy < OW'(DEPTH);
   assign out_valid   = occupancy != '0;
   assign out_bus     = out_valid ? mem[rd_ptr] : '0;
   assign push        = in_valid & in_allow_in;
   assign pop         = out_valid & out_allow_in;

   // payload storage; stale entries are masked by out_valid so no reset is needed
   always_ff @(posedge clk) begin
      if (push & ~flush) mem[wr_ptr] <= in_bus;
   end

   // pointers and occupancy; flush wins over any same-cycle push or pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else if (flush) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) wr_ptr <= inc(wr_ptr);
         if (pop) rd_ptr <= inc(rd_ptr);
         if (push & ~pop) occupancy <= occupancy + 1'b1;
         else if (pop & ~push) occupancy <= occupancy - 1'b1;
      end
   end

   // saturating count of back-pressured cycles; survives flush, cleared only by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) stall_cnt <= '0;
      else if (out_valid & ~out_allow_in & ~flush & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
   end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed scenario checks over several pipe_stage_buf configurations
module tb_pipe_stage_buf;
   logic       clk = 0, reset = 0, in_valid = 0, out_allow_in = 0, flush = 0;
   logic [7:0] in_bus = 0;
   int tests = 0, fails = 0;

   logic       a2_ai, a2_ov, a3_ai, a3_ov, s3_ai, s3_ov, a4_ai, a4_ov;
   logic [7:0] a2_ob, a3_ob, s3_ob, a4_ob;
   logic [1:0] a2_oc, a3_oc, s3_oc;
   logic [2:0] a4_oc;
   logic [15:0] a2_sc, a3_sc, a4_sc;
   logic [2:0]  s3_sc;

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(8), .DEPTH(2), .CNT_W(16)) u2 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_bus(in_bus),
      .in_allow_in(a2_ai), .out_valid(a2_ov), .out_bus(a2_ob), .out_allow_in(out_allow_in), .flush(flush), .occupancy(a2_oc), .stall_cnt(a2_sc));
   pipe_stage_buf #(.DATA_W(8), .DEPTH(3), .CNT_W(16)) u3 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_bus(in_bus),
      .in_allow_in(a3_ai), .out_valid(a3_ov), .out_bus(a3_ob), .out_allow_in(out_allow_in), .flush(flush), .occupancy(a3_oc), .stall_cnt(a3_sc));
   pipe_stage_buf #(.DATA_W(8), .DEPTH(3), .CNT_W(3)) u3s (.clk(clk), .reset(reset), .in_valid(in_valid), .in_bus(in_bus),
      .in_allow_in(s3_ai), .out_valid(s3_ov), .out_bus(s3_ob), .out_allow_in(out_allow_in), .flush(flush), .occupancy(s3_oc), .stall_cnt(s3_sc));
   pipe_stage_buf #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) u4 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_bus(in_bus),
      .in_allow_in(a4_ai), .out_valid(a4_ov), .out_bus(a4_ob), .out_allow_in(out_allow_in), .flush(flush), .occupancy(a4_oc), .stall_cnt(a4_sc));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 0; out_allow_in = 0; flush = 0; in_bus = 0;
      reset = 1;
      step();
      step();
      reset = 0;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if ({a2_oc, a2_ov, a2_ob, a2_sc, a2_ai} !== {2'd0, 1'b0, 8'd0, 16'd0, 1'b1}) begin fails++; $display("FAIL reset_d2: got occ=%0d ov=%0b ob=%0h sc=%0d ai=%0b expected 0 0 0 0 1", a2_oc, a2_ov, a2_ob, a2_sc, a2_ai); end
      tests++; if ({a3_oc, a3_ov, a3_ob, a3_sc, a3_ai} !== {2'd0, 1'b0, 8'd0, 16'd0, 1'b1}) begin fails++; $display("FAIL reset_d3: got occ=%0d ov=%0b ob=%0h sc=%0d ai=%0b expected 0 0 0 0 1", a3_oc, a3_ov, a3_ob, a3_sc, a3_ai); end
      tests++; if ({a4_oc, a4_ov, a4_ob, a4_sc, a4_ai} !== {3'd0, 1'b0, 8'd0, 16'd0, 1'b1}) begin fails++; $display("FAIL reset_d4: got occ=%0d ov=%0b ob=%0h sc=%0d ai=%0b expected 0 0 0 0 1", a4_oc, a4_ov, a4_ob, a4_sc, a4_ai); end
   endtask

   task automatic test_stream();
      do_reset();
      out_allow_in = 1;
      in_valid = 1;
      for (int i = 1; i <= 10; i++) begin
         in_bus = 8'(i);
         step();
         tests++; if (a2_ov !== 1'b1 || a2_ob !== 8'(i)) begin fails++; $display("FAIL stream_out[%0d]: got ov=%0b ob=%0h expected 1 %0h", i, a2_ov, a2_ob, i); end
         tests++; if (a2_ai !== 1'b1) begin fails++; $display("FAIL stream_allow[%0d]: got %0b expected 1", i, a2_ai); end
      end
      in_valid = 0;
      step();
      tests++; if (a2_ov !== 1'b0 || a2_sc !== 16'd0) begin fails++; $display("FAIL stream_end: got ov=%0b sc=%0d expected 0 0", a2_ov, a2_sc); end
   endtask

   task automatic test_backpressure();
      do_reset();
      in_valid = 1;
      in_bus = 8'hA; step();
      in_bus = 8'hB; step();
      in_bus = 8'hC; step();
      tests++; if (a3_oc !== 2'd3 || a3_ai !== 1'b0 || a3_ob !== 8'hA) begin fails++; $display("FAIL bp_full: got occ=%0d ai=%0b ob=%0h expected 3 0 a", a3_oc, a3_ai, a3_ob); end
      in_bus = 8'hD; step();
      tests++; if (a3_oc !== 2'd3 || a3_ob !== 8'hA) begin fails++; $display("FAIL bp_reject: got occ=%0d ob=%0h expected 3 a", a3_oc, a3_ob); end
      out_allow_in = 1;
      step();
      tests++; if (a3_oc !== 2'd2 || a3_ob !== 8'hB || a3_ai !== 1'b1) begin fails++; $display("FAIL bp_pop_a: got occ=%0d ob=%0h ai=%0b expected 2 b 1", a3_oc, a3_ob, a3_ai); end
      step();
      tests++; if (a3_oc !== 2'd2 || a3_ob !== 8'hC) begin fails++; $display("FAIL bp_pop_b: got occ=%0d ob=%0h expected 2 c", a3_oc, a3_ob); end
      in_valid = 0;
      step();
      tests++; if (a3_oc !== 2'd1 || a3_ob !== 8'hD) begin fails++; $display("FAIL bp_pop_c: got occ=%0d ob=%0h expected 1 d", a3_oc, a3_ob); end
      step();
      tests++; if (a3_oc !== 2'd0 || a3_ov !== 1'b0 || a3_ob !== 8'h0) begin fails++; $display("FAIL bp_empty: got occ=%0d ov=%0b ob=%0h expected 0 0 0", a3_oc, a3_ov, a3_ob); end
   endtask

   task automatic test_stall();
      do_reset();
      in_valid = 1; in_bus = 8'h5;
      step();
      in_valid = 0;
      repeat (5) step();
      tests++; if (a3_sc !== 16'd5) begin fails++; $display("FAIL stall_5: got %0d expected 5", a3_sc); end
      tests++; if (s3_sc !== 3'd5) begin fails++; $display("FAIL stall_5_narrow: got %0d expected 5", s3_sc); end
      repeat (15) step();
      tests++; if (s3_sc !== 3'd7) begin fails++; $display("FAIL stall_sat: got %0d expected 7", s3_sc); end
      tests++; if (a3_sc !== 16'd20) begin fails++; $display("FAIL stall_20: got %0d expected 20", a3_sc); end
      flush = 1;
      step();
      flush = 0;
      tests++; if (a3_sc !== 16'd20 || a3_oc !== 2'd0) begin fails++; $display("FAIL stall_flush: got sc=%0d occ=%0d expected 20 0", a3_sc, a3_oc); end
   endtask

   task automatic test_flush();
      do_reset();
      in_valid = 1;
      in_bus = 8'h1; step();
      in_bus = 8'h2; step();
      in_bus = 8'h3; step();
      tests++; if (a4_oc !== 3'd3 || a4_ob !== 8'h1) begin fails++; $display("FAIL flush_pre: got occ=%0d ob=%0h expected 3 1", a4_oc, a4_ob); end
      flush = 1; in_bus = 8'h55; out_allow_in = 1;
      step();
      flush = 0;
      tests++; if (a4_oc !== 3'd0 || a4_ov !== 1'b0 || a4_ob !== 8'h0) begin fails++; $display("FAIL flush_clear: got occ=%0d ov=%0b ob=%0h expected 0 0 0", a4_oc, a4_ov, a4_ob); end
      in_bus = 8'h66;
      step();
      in_valid = 0;
      tests++; if (a4_oc !== 3'd1 || a4_ob !== 8'h66) begin fails++; $display("FAIL flush_next: got occ=%0d ob=%0h expected 1 66", a4_oc, a4_ob); end
      step();
      tests++; if (a4_oc !== 3'd0 || a4_ov !== 1'b0) begin fails++; $display("FAIL flush_drain: got occ=%0d ov=%0b expected 0 0", a4_oc, a4_ov); end
   endtask

   task automatic test_wrap();
      int sent, got;
      sent = 0; got = 0;
      do_reset();
      for (int c = 0; c < 80 && got < 12; c++) begin
         in_valid = sent < 12;
         in_bus = 8'(sent);
         out_allow_in = (c % 3) != 0;
         #1;
         if (a3_ov && out_allow_in) begin
            tests++; if (a3_ob !== 8'(got)) begin fails++; $display("FAIL wrap_seq[%0d]: got %0h expected %0h", got, a3_ob, got); end
            got++;
         end
         if (in_valid && a3_ai) sent++;
         step();
      end
      tests++; if (got != 12) begin fails++; $display("FAIL wrap_count: got %0d expected 12", got); end
      in_valid = 0; out_allow_in = 0;
   endtask

   task automatic test_async_reset();
      do_reset();
      in_valid = 1; in_bus = 8'h11; step();
      in_bus = 8'h22; step();
      in_valid = 0;
      repeat (3) step();
      tests++; if (a3_oc !== 2'd2 || a3_sc !== 16'd4) begin fails++; $display("FAIL areset_pre: got occ=%0d sc=%0d expected 2 4", a3_oc, a3_sc); end
      #2 reset = 1;
      #1;
      tests++; if ({a3_oc, a3_ov, a3_ob, a3_sc, a3_ai} !== {2'd0, 1'b0, 8'd0, 16'd0, 1'b1}) begin fails++; $display("FAIL areset_now: got occ=%0d ov=%0b ob=%0h sc=%0d ai=%0b expected 0 0 0 0 1", a3_oc, a3_ov, a3_ob, a3_sc, a3_ai); end
      #2 reset = 0;
      step();
      tests++; if (a3_ai !== 1'b1 || a3_oc !== 2'd0) begin fails++; $display("FAIL areset_after: got ai=%0b occ=%0d expected 1 0", a3_ai, a3_oc); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_stall();
      test_flush();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline buffer for the 5-stage core (IF/ID/EX/ME/WB); carries a stage bus between producer and consumer using the valid / allow_in handshake.
- Generalises the single-entry stage register to a DEPTH-entry elastic buffer with:
  - a registered (non-combinational) allow_in, which breaks the backward ready path;
  - a flush input for branch/exception squash;
  - a saturating back-pressure stall counter for performance debug.

Parameters:
- DATA_W, 64, width of the carried stage bus (e.g. 64 IF->ID, 150 ID->EX).
- DEPTH, 2, number of entries; legal 1..8, any integer; DEPTH>=2 required for full throughput.
- CNT_W, 16, width of stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream holds a valid bus (e.g. IF_to_ID_Valid).
- in_bus  in  DATA_W  upstream payload.
- in_allow_in  out  1  buffer can accept this cycle; function of registered state only.
- out_valid  out  1  head entry valid toward downstream.
- out_bus  out  DATA_W  head entry payload.
- out_allow_in  in  1  downstream accepts (e.g. EX_Allow_in).
- flush  in  1  discard all contents at next edge.
- occupancy  out  $clog2(DEPTH+1)  current entry count.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_allow_in=0, saturating.

Behaviour:
- Reset (async assert, sync deassert by system): occupancy=0, out_valid=0, out_bus=0, stall_cnt=0, pointers=0. in_allow_in=1 after reset.
- Definitions: push = in_valid & in_allow_in; pop = out_valid & out_allow_in.
- in_allow_in = (occupancy < DEPTH). It does not depend on out_allow_in, so it is 0 when full even if a pop occurs in the same cycle.
- out_valid = (occupancy != 0).
- out_bus = storage[rd_ptr]; zero when empty. Storage need not be cleared on pop, but out_bus must read 0 whenever out_valid=0.
- Latency: a push at edge N makes the data visible on out_bus/out_valid after edge N (1 cycle), including when the buffer was empty. There is no combinational in->out bypass.
- Push with no pop: write storage[wr_ptr], wr_ptr++, occupancy++.
- Pop with no push: rd_ptr++, occupancy--.
- Push and pop together: both pointers advance, occupancy unchanged, and FIFO order is preserved. This is legal when occupancy is 1..DEPTH-1. When DEPTH=1 it cannot occur, because in_allow_in=0 while full.
- Pointer wrap: pointer at DEPTH-1 increments to 0. Non-power-of-two DEPTH must wrap correctly.
- Flush (sync, highest priority): at the edge, occupancy=0, rd_ptr=wr_ptr=0, and out_valid=0 afterwards. Any push or pop in the same cycle is discarded. Upstream treats a discarded push as squashed. stall_cnt is not cleared.
- stall_cnt: increments by 1 every cycle with out_valid & ~out_allow_in & ~flush; holds at 2^CNT_W-1. Cleared only by reset.
- Upstream protocol: in_bus must be stable only in the cycle push is evaluated. Downstream may deassert out_allow_in arbitrarily. Contents are never lost or duplicated except via flush/reset.
- Reset asserted mid-operation: immediate return to the reset state; no partial write.

Test Plan:
1. DEPTH=2, out_allow_in=1, in_valid=1 for 10 cycles with in_bus=1..10 -> out_bus 1..10 on consecutive cycles starting one cycle after the first push; in_allow_in stays 1; stall_cnt=0.
2. DEPTH=3, out_allow_in=0, push 0xA,0xB,0xC -> occupancy=3, in_allow_in=0. A fourth offered value 0xD is not accepted. Release out_allow_in -> pops in order A,B,C,D, with D accepted the cycle after occupancy drops to 2.
3. DEPTH=3, out_valid=1 with out_allow_in=0 for 5 cycles -> stall_cnt=5. With CNT_W=3 and a 20-cycle stall -> stall_cnt saturates at 7.
4. DEPTH=4, occupancy=3, assert flush together with in_valid=1 (in_bus=0x55) and out_allow_in=1 -> next cycle occupancy=0, out_valid=0, out_bus=0. 0x55 never appears at the output. The next push 0x66 appears one cycle later.
5. DEPTH=3, interleave push/pop so wr_ptr wraps twice with in_bus=0..11 -> output sequence 0..11 exact, no gaps or duplicates.
6. Assert reset asynchronously mid-cycle with occupancy=2 and stall_cnt=4 -> outputs go to the reset state before the next clock edge; after deassert, in_allow_in=1.
